pck_echo_responder: RTL and testbench

//  Responder endpoint on a packet_injector control interface. It consumes packets delivered by the

---
 rtl/pck_echo_responder_pkg.sv | 41 ++++
 rtl/pck_echo_fifo.sv | 46 ++++
 rtl/pck_echo_responder.sv | 117 +++++++++++
 tb/tb_pck_echo_responder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pck_echo_responder_pkg.sv
// Shared types for the echo responder: injector packet view, FIFO entry and FSM state.
package pck_echo_responder_pkg;

  localparam int V        = 2;
  localparam int EAw      = 4;
  localparam int PCK_SIZw = 4;
  localparam int DATA_w   = 16;
  localparam int Cw       = 2;
  localparam int WEIGHTw  = 4;

  typedef struct packed {
    logic [DATA_w-1:0]   data;
    logic [PCK_SIZw-1:0] size;
    logic [EAw-1:0]      endp_addr;
    logic [Cw-1:0]       class_num;
    logic [WEIGHTw-1:0]  init_weight;
    logic [V-1:0]        vc;
    logic [V-1:0]        ready;
    logic                pck_wr;
  } pck_injct_t;

  typedef struct packed {
    logic [EAw-1:0]      endp_addr;
    logic [PCK_SIZw-1:0] size;
    logic [DATA_w-1:0]   data;
  } echo_entry_t;

  localparam int ECHO_STATE_W = 2;

  typedef enum logic [ECHO_STATE_W-1:0] {
    ST_IDLE,
    ST_ARM,
    ST_ISSUE,
    ST_GAP
  } echo_state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pck_echo_fifo.sv
// Pending-response FIFO with first-word-fall-through head; wrap-bit pointers give full/empty.
module pck_echo_fifo
  import pck_echo_responder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  echo_entry_t wdata,
  output echo_entry_t head,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);

  echo_entry_t     mem [DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/pck_echo_responder.sv
// Echo responder: queues class-REQ packets and returns each to its source with data+1.
module pck_echo_responder
  import pck_echo_responder_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int RSP_VC    = 0,
  parameter int REQ_CLASS = 0,
  parameter int RSP_CLASS = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  pck_injct_t   rx_pck,
  output pck_injct_t   tx_pck,
  input  logic [V-1:0] rdy_vec,
  output logic [31:0]  rx_cnt,
  output logic [31:0]  tx_cnt,
  output logic [31:0]  drop_cnt,
  output logic [31:0]  ign_cnt
);

  echo_state_t         state, next_state;
  echo_entry_t         fifo_wdata, fifo_head;
  logic                fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic                is_req, is_other, rx_drop, load_tx;
  logic                tx_wr;
  logic [EAw-1:0]      tx_dest;
  logic [PCK_SIZw-1:0] tx_size;
  logic [DATA_w-1:0]   tx_data;

  assign is_req     = rx_pck.pck_wr && (rx_pck.class_num == Cw'(REQ_CLASS));
  assign is_other   = rx_pck.pck_wr && (rx_pck.class_num != Cw'(REQ_CLASS));
  assign fifo_pop   = (state == ST_ISSUE);
  // A pop on the same edge frees a slot, so a full FIFO still accepts.
  assign fifo_push  = is_req && (!fifo_full || fifo_pop);
  assign rx_drop    = is_req && fifo_full && !fifo_pop;
  assign fifo_wdata = '{endp_addr: rx_pck.endp_addr, size: rx_pck.size, data: rx_pck.data};

  pck_echo_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // NOTE: defaults first so every path assigns every output; no latches.
  always_comb begin
    next_state = state;
    load_tx    = 1'b0;
    case (state)
      ST_IDLE:  if (!fifo_empty && enable) next_state = ST_ARM;
      ST_ARM: begin
        if (!enable) begin
          next_state = ST_IDLE;
        end else if (rdy_vec[RSP_VC]) begin
          next_state = ST_ISSUE;
          load_tx    = 1'b1;
        end
      end
      ST_ISSUE: next_state = ST_GAP;
      ST_GAP:   next_state = (!fifo_empty && enable) ? ST_ARM : ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wr   <= 1'b0;
      tx_dest <= '0;
      tx_size <= '0;
      tx_data <= '0;
    end else begin
      tx_wr <= load_tx;
      if (load_tx) begin
        tx_dest <= fifo_head.endp_addr;
        tx_size <= fifo_head.size;
        tx_data <= fifo_head.data + DATA_w'(1);
      end
    end
  end

  always_comb begin
    tx_pck             = '0;
    tx_pck.pck_wr      = tx_wr;
    tx_pck.endp_addr   = tx_dest;
    tx_pck.size        = tx_size;
    tx_pck.data        = tx_data;
    tx_pck.class_num   = Cw'(RSP_CLASS);
    tx_pck.vc          = V'(1) << RSP_VC;
    tx_pck.init_weight = WEIGHTw'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_cnt   <= '0;
      tx_cnt   <= '0;
      drop_cnt <= '0;
      ign_cnt  <= '0;
    end else begin
      if (fifo_push)           rx_cnt   <= sat_inc(rx_cnt);
      if (state == ST_ISSUE)   tx_cnt   <= sat_inc(tx_cnt);
      if (rx_drop)             drop_cnt <= sat_inc(drop_cnt);
      if (is_other)            ign_cnt  <= sat_inc(ign_cnt);
    end
  end

endmodule

// File: tb/tb_pck_echo_responder.sv
// Directed bench for pck_echo_responder: vector table plus multi-cycle corner sequences.
module tb_pck_echo_responder;
  import pck_echo_responder_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  pck_injct_t   rx_pck;
  pck_injct_t   tx_pck;
  logic [V-1:0] rdy_vec;
  logic [31:0]  rx_cnt, tx_cnt, drop_cnt, ign_cnt;

  pck_injct_t   tx_b;
  logic [31:0]  rx_b, txc_b, drop_b, ign_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pck_echo_responder dut (
    .clk(clk), .reset(reset), .enable(enable), .rx_pck(rx_pck), .tx_pck(tx_pck),
    .rdy_vec(rdy_vec), .rx_cnt(rx_cnt), .tx_cnt(tx_cnt), .drop_cnt(drop_cnt), .ign_cnt(ign_cnt)
  );

  // Second responder fed by the first one's responses: must ignore them all.
  pck_echo_responder dut_b (
    .clk(clk), .reset(reset), .enable(1'b1), .rx_pck(tx_pck), .tx_pck(tx_b),
    .rdy_vec(2'b11), .rx_cnt(rx_b), .tx_cnt(txc_b), .drop_cnt(drop_b), .ign_cnt(ign_b)
  );

  typedef struct {
    logic [3:0]  src;
    logic [3:0]  size;
    logic [15:0] data;
    logic [1:0]  cls;
    bit          exp_tx;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [3:0] src, input logic [3:0] size,
                      input logic [15:0] data, input logic [1:0] cls);
    rx_pck.pck_wr    = 1'b1;
    rx_pck.endp_addr = src;
    rx_pck.size      = size;
    rx_pck.data      = data;
    rx_pck.class_num = cls;
    cyc();
    rx_pck = '0;
  endtask

  task automatic wait_tx(input int budget, output bit found, output int lat);
    found = 1'b0;
    lat   = 0;
    for (int i = 0; i < budget; i++) begin
      cyc();
      lat++;
      if (tx_pck.pck_wr) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rx_pck  = '0;
    rdy_vec = '0;
    enable  = 1'b1;
    reset   = 1'b1;
    #1;
    check("rst pck_wr",      32'(tx_pck.pck_wr), 32'd0);
    check("rst vc",          32'(tx_pck.vc), 32'h1);
    check("rst init_weight", 32'(tx_pck.init_weight), 32'd1);
    check("rst class",       32'(tx_pck.class_num), 32'd1);
    check("rst data",        32'(tx_pck.data), 32'd0);
    check("rst rx_cnt",      rx_cnt, 32'd0);
    check("rst tx_cnt",      tx_cnt, 32'd0);
    check("rst drop_cnt",    drop_cnt, 32'd0);
    check("rst ign_cnt",     ign_cnt, 32'd0);
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          found;
    int          lat;
    int          exp_rx, exp_tx, exp_ign;
    logic [15:0] exp_q[4];

    vecs[0] = '{4'd1,  4'd5,  16'h0010, 2'd0, 1'b1, 16'h0011};
    vecs[1] = '{4'd7,  4'd1,  16'hFFFF, 2'd0, 1'b1, 16'h0000};
    vecs[2] = '{4'd3,  4'd2,  16'h1234, 2'd1, 1'b0, 16'h0000};
    vecs[3] = '{4'd15, 4'd15, 16'h7FFF, 2'd0, 1'b1, 16'h8000};
    vecs[4] = '{4'd0,  4'd0,  16'h0000, 2'd2, 1'b0, 16'h0000};

    reset = 1'b1;
    @(negedge clk);

    // Table: one request at a time, ready high.
    do_reset();
    rdy_vec = 2'b11;
    exp_rx = 0; exp_tx = 0; exp_ign = 0;
    for (int i = 0; i < 5; i++) begin
      send(vecs[i].src, vecs[i].size, vecs[i].data, vecs[i].cls);
      wait_tx(6, found, lat);
      check($sformatf("v%0d tx seen", i), 32'(found), 32'(vecs[i].exp_tx));
      if (vecs[i].exp_tx) begin
        exp_rx++;
        exp_tx++;
        check($sformatf("v%0d latency", i), 32'(lat + 1), 32'd3);
        check($sformatf("v%0d endp", i),  32'(tx_pck.endp_addr), 32'(vecs[i].src));
        check($sformatf("v%0d size", i),  32'(tx_pck.size), 32'(vecs[i].size));
        check($sformatf("v%0d data", i),  32'(tx_pck.data), 32'(vecs[i].exp_data));
        check($sformatf("v%0d class", i), 32'(tx_pck.class_num), 32'd1);
        cyc();
        check($sformatf("v%0d one pulse", i), 32'(tx_pck.pck_wr), 32'd0);
        check($sformatf("v%0d data held", i), 32'(tx_pck.data), 32'(vecs[i].exp_data));
        cyc();
      end else begin
        exp_ign++;
      end
      check($sformatf("v%0d rx_cnt", i),  rx_cnt, 32'(exp_rx));
      check($sformatf("v%0d tx_cnt", i),  tx_cnt, 32'(exp_tx));
      check($sformatf("v%0d ign_cnt", i), ign_cnt, 32'(exp_ign));
    end
    check("loop b ign_cnt", ign_b, 32'd3);
    check("loop b tx_cnt",  txc_b, 32'd0);
    check("loop b rx_cnt",  rx_b,  32'd0);

    // Burst of 6 into a 4-deep FIFO, ready low.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      rx_pck.pck_wr    = 1'b1;
      rx_pck.endp_addr = 4'(i);
      rx_pck.size      = 4'd3;
      rx_pck.data      = 16'h0100 + 16'(i);
      rx_pck.class_num = 2'd0;
      cyc();
    end
    rx_pck = '0;
    cyc();
    check("burst rx_cnt",   rx_cnt,   32'd4);
    check("burst drop_cnt", drop_cnt, 32'd2);
    rdy_vec = 2'b10;
    wait_tx(5, found, lat);
    check("burst wrong vc ready", 32'(found), 32'd0);
    rdy_vec = 2'b01;
    for (int k = 0; k < 4; k++) begin
      wait_tx(8, found, lat);
      check($sformatf("burst r%0d seen", k), 32'(found), 32'd1);
      check($sformatf("burst r%0d data", k), 32'(tx_pck.data), 32'h0101 + 32'(k));
      check($sformatf("burst r%0d endp", k), 32'(tx_pck.endp_addr), 32'(k));
      if (k > 0) check($sformatf("burst r%0d spacing", k), 32'(lat), 32'd3);
    end
    cyc();
    check("burst tx_cnt", tx_cnt, 32'd4);

    // Full FIFO, request lands on the ISSUE edge.
    do_reset();
    for (int i = 0; i < 4; i++) send(4'(i + 4), 4'd1, 16'h0020 + 16'(i), 2'd0);
    cyc();
    cyc();
    rdy_vec = 2'b01;
    cyc();
    check("full issue pulse", 32'(tx_pck.pck_wr), 32'd1);
    check("full issue data",  32'(tx_pck.data), 32'h21);
    send(4'd9, 4'd2, 16'h0030, 2'd0);
    check("full pop drop_cnt", drop_cnt, 32'd0);
    check("full pop rx_cnt",   rx_cnt,   32'd5);
    exp_q[0] = 16'h0022; exp_q[1] = 16'h0023; exp_q[2] = 16'h0024; exp_q[3] = 16'h0031;
    for (int k = 0; k < 4; k++) begin
      wait_tx(8, found, lat);
      check($sformatf("full r%0d seen", k), 32'(found), 32'd1);
      check($sformatf("full r%0d data", k), 32'(tx_pck.data), 32'(exp_q[k]));
    end

    // Reset asserted mid-ISSUE with a second request still queued.
    do_reset();
    rdy_vec = 2'b01;
    send(4'd2, 4'd1, 16'h0040, 2'd0);
    send(4'd3, 4'd1, 16'h0050, 2'd0);
    wait_tx(6, found, lat);
    check("rst-issue pulse seen", 32'(found), 32'd1);
    reset = 1'b1;
    #1;
    check("rst-issue pck_wr killed", 32'(tx_pck.pck_wr), 32'd0);
    check("rst-issue rx_cnt",        rx_cnt, 32'd0);
    cyc();
    reset = 1'b0;
    wait_tx(8, found, lat);
    check("rst-issue fifo flushed", 32'(found), 32'd0);
    check("rst-issue tx_cnt",       tx_cnt, 32'd0);

    // enable low holds the queue; raising it releases both responses.
    do_reset();
    rdy_vec = 2'b01;
    enable  = 1'b0;
    send(4'd5, 4'd4, 16'h0060, 2'd0);
    send(4'd6, 4'd4, 16'h0070, 2'd0);
    wait_tx(10, found, lat);
    check("en0 no tx",   32'(found), 32'd0);
    check("en0 rx_cnt",  rx_cnt, 32'd2);
    check("en0 tx_cnt",  tx_cnt, 32'd0);
    enable = 1'b1;
    wait_tx(8, found, lat);
    check("en1 r0 seen", 32'(found), 32'd1);
    check("en1 r0 data", 32'(tx_pck.data), 32'h61);
    wait_tx(8, found, lat);
    check("en1 r1 seen", 32'(found), 32'd1);
    check("en1 r1 data", 32'(tx_pck.data), 32'h71);
    check("en1 r1 endp", 32'(tx_pck.endp_addr), 32'd6);
    cyc();
    check("en1 tx_cnt",  tx_cnt, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
